// File: rtl/uart_frame_parser_pkg.sv
// Shared definitions for the UART command framer: state encoding and frame constants.
package uart_frame_parser_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ADDR = 3'd1,
        ST_DHI  = 3'd2,
        ST_DLO  = 3'd3,
        ST_CHK  = 3'd4
    } state_t;

    localparam logic [7:0]  SYNC_BYTE = 8'hA5;
    localparam int unsigned FRAME_LEN = 5;

endpackage

// File: rtl/uart_frame_parser_timeout.sv
// Inter-byte idle counter; flags a stalled frame when the gap reaches TIMEOUT cycles.
module frame_timeout #(
    parameter int unsigned TIMEOUT = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic run,
    output logic expired
);

    localparam int unsigned W = $clog2(TIMEOUT + 1);
    localparam logic [W-1:0] LIMIT = W'(TIMEOUT);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr || !run || cnt == LIMIT) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + W'(1);
        end
    end

    // A byte arriving on the limit cycle suppresses the expiry
    assign expired = run && !clr && (cnt == LIMIT);

endmodule

// File: rtl/uart_frame_parser.sv
// Assembles SYNC/ADDR/DHI/DLO/CHK frames from UART bytes and emits validated register writes.
module uart_frame_parser
    import uart_frame_parser_pkg::*;
#(
    parameter logic [7:0]  SYNC    = SYNC_BYTE,
    parameter int unsigned TIMEOUT = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rcv,
    input  logic [7:0]  data,
    output logic        wr_en,
    output logic [7:0]  wr_addr,
    output logic [15:0] wr_data,
    output logic        frame_err,
    output logic        tout_err
);

    state_t     state, state_next;
    logic [7:0] addr_q, hi_q, lo_q, chk_q;
    logic       tout_hit, fire_wr, fire_ferr;

    frame_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clr     (rcv),
        .run     (state != ST_IDLE),
        .expired (tout_hit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (tout_hit) begin
            state_next = ST_IDLE;
        end else if (rcv) begin
            case (state)
                ST_IDLE: if (data == SYNC) state_next = ST_ADDR;
                ST_ADDR: state_next = ST_DHI;
                ST_DHI:  state_next = ST_DLO;
                ST_DLO:  state_next = ST_CHK;
                ST_CHK:  state_next = ST_IDLE;
                default: state_next = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        fire_wr   = 1'b0;
        fire_ferr = 1'b0;
        if (rcv && !tout_hit && state == ST_CHK) begin
            fire_wr   = (data == chk_q);
            fire_ferr = (data != chk_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q    <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            chk_q     <= '0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            frame_err <= 1'b0;
            tout_err  <= 1'b0;
        end else begin
            wr_en     <= fire_wr;
            frame_err <= fire_ferr;
            tout_err  <= tout_hit;
            if (fire_wr) begin
                wr_addr <= addr_q;
                wr_data <= {hi_q, lo_q};
            end
            if (rcv && !tout_hit) begin
                case (state)
                    ST_IDLE: if (data == SYNC) chk_q <= '0;
                    ST_ADDR: begin addr_q <= data; chk_q <= chk_q ^ data; end
                    ST_DHI:  begin hi_q   <= data; chk_q <= chk_q ^ data; end
                    ST_DLO:  begin lo_q   <= data; chk_q <= chk_q ^ data; end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_frame_parser.sv
// Directed plus randomized byte streams checked against a transaction-level frame model.
module tb_uart_frame_parser;

    localparam int unsigned TIMEOUT = 100;
    localparam logic [7:0]  SYNC    = 8'hA5;

    logic        clk = 1'b0;
    logic        rst, rcv;
    logic [7:0]  data, wr_addr;
    logic [15:0] wr_data;
    logic        wr_en, frame_err, tout_err;

    uart_frame_parser #(.SYNC(SYNC), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .rst       (rst),
        .rcv       (rcv),
        .data      (data),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .frame_err (frame_err),
        .tout_err  (tout_err)
    );

    always #5 clk = ~clk;

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // kind: 0 = write, 1 = checksum error, 2 = timeout; at = edge that registered the pulse
    typedef struct {
        int          kind;
        longint      at;
        logic [7:0]  a;
        logic [15:0] d;
    } ev_t;

    ev_t exp_q[$];
    ev_t act_q[$];

    always @(negedge clk) begin
        if (wr_en)     act_q.push_back('{0, cyc, wr_addr, wr_data});
        if (frame_err) act_q.push_back('{1, cyc, 8'h00, 16'h0000});
        if (tout_err)  act_q.push_back('{2, cyc, 8'h00, 16'h0000});
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    bit          in_frame = 1'b0;
    logic [7:0]  fb[$];
    longint      last_edge = 0;
    logic [7:0]  exp_addr = 8'h00;
    logic [15:0] exp_data = 16'h0000;

    task automatic model_flush(input longint now);
        if (in_frame && now >= last_edge + TIMEOUT + 1) begin
            exp_q.push_back('{2, last_edge + TIMEOUT + 1, 8'h00, 16'h0000});
            in_frame = 1'b0;
        end
    endtask

    task automatic model_byte(input logic [7:0] b, input longint e);
        logic [7:0] x;
        model_flush(e - 1);
        if (!in_frame) begin
            if (b == SYNC) begin
                in_frame  = 1'b1;
                fb.delete();
                last_edge = e;
            end
        end else begin
            last_edge = e;
            if (fb.size() == 3) begin
                x = fb[0] ^ fb[1] ^ fb[2];
                if (b == x) begin
                    exp_addr = fb[0];
                    exp_data = {fb[1], fb[2]};
                    exp_q.push_back('{0, e, exp_addr, exp_data});
                end else begin
                    exp_q.push_back('{1, e, 8'h00, 16'h0000});
                end
                in_frame = 1'b0;
            end else begin
                fb.push_back(b);
            end
        end
    endtask

    task automatic model_reset();
        in_frame = 1'b0;
        fb.delete();
        exp_addr = 8'h00;
        exp_data = 16'h0000;
    endtask

    task automatic drive_byte(input logic [7:0] b);
        @(negedge clk);
        rcv  = 1'b1;
        data = b;
        @(posedge clk);
        #1;
        model_byte(b, cyc);
    endtask

    task automatic idle(input int unsigned n);
        repeat (n) begin
            @(negedge clk);
            rcv  = 1'b0;
            data = 8'($urandom);
            @(posedge clk);
        end
    endtask

    task automatic finish_scenario(input string tag);
        int unsigned n;
        idle(4);
        #1;
        model_flush(cyc);
        check($sformatf("%s_events", tag), 64'(act_q.size()), 64'(exp_q.size()));
        n = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
        for (int unsigned i = 0; i < n; i++) begin
            check($sformatf("%s_ev%0d_kind", tag, i), 64'(act_q[i].kind), 64'(exp_q[i].kind));
            check($sformatf("%s_ev%0d_cycle", tag, i), 64'(act_q[i].at), 64'(exp_q[i].at));
            check($sformatf("%s_ev%0d_addr", tag, i), 64'(act_q[i].a), 64'(exp_q[i].a));
            check($sformatf("%s_ev%0d_data", tag, i), 64'(act_q[i].d), 64'(exp_q[i].d));
        end
        check($sformatf("%s_wr_addr_hold", tag), 64'(wr_addr), 64'(exp_addr));
        check($sformatf("%s_wr_data_hold", tag), 64'(wr_data), 64'(exp_data));
        act_q.delete();
        exp_q.delete();
    endtask

    task automatic check_all_zero(input string tag);
        check($sformatf("%s_wr_en", tag),     64'(wr_en),     64'(0));
        check($sformatf("%s_wr_addr", tag),   64'(wr_addr),   64'(0));
        check($sformatf("%s_wr_data", tag),   64'(wr_data),   64'(0));
        check($sformatf("%s_frame_err", tag), 64'(frame_err), 64'(0));
        check($sformatf("%s_tout_err", tag),  64'(tout_err),  64'(0));
    endtask

    initial begin
        logic [7:0] fr[5];
        logic [7:0] b;
        int unsigned stall_pos, gap, nj;

        rst  = 1'b1;
        rcv  = 1'b0;
        data = 8'h00;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        drive_byte(8'hA5); drive_byte(8'h12); drive_byte(8'h34); drive_byte(8'h56); drive_byte(8'h70);
        finish_scenario("valid");

        drive_byte(8'hA5); drive_byte(8'h12); drive_byte(8'h34); drive_byte(8'h56); drive_byte(8'h71);
        finish_scenario("badchk");

        drive_byte(8'h00); drive_byte(8'hFF); drive_byte(8'h5A);
        drive_byte(8'hA5); drive_byte(8'h12); drive_byte(8'h34); drive_byte(8'h56); drive_byte(8'h70);
        finish_scenario("junk");

        drive_byte(8'hA5); drive_byte(8'h12);
        idle(150);
        finish_scenario("timeout");
        drive_byte(8'hA5); drive_byte(8'h3C); drive_byte(8'h0F); drive_byte(8'hF0); drive_byte(8'hC3);
        finish_scenario("after_timeout");

        drive_byte(8'hA5); drive_byte(8'h01); drive_byte(8'h00); drive_byte(8'hFF); drive_byte(8'hFE);
        drive_byte(8'hA5); drive_byte(8'h02); drive_byte(8'hAB); drive_byte(8'hCD); drive_byte(8'h64);
        finish_scenario("back2back");

        drive_byte(8'hA5);
        idle(TIMEOUT);
        drive_byte(8'h21); drive_byte(8'h43); drive_byte(8'h65); drive_byte(8'h07);
        finish_scenario("boundary");

        drive_byte(8'hA5); drive_byte(8'h12); drive_byte(8'h34);
        @(negedge clk);
        rcv = 1'b0;
        rst = 1'b1;
        #1;
        check_all_zero("midreset");
        model_reset();
        idle(2);
        @(negedge clk);
        rst = 1'b0;
        drive_byte(8'h56); drive_byte(8'h70);
        finish_scenario("after_reset");

        for (int f = 0; f < 20; f++) begin
            nj = $urandom_range(0, 3);
            for (int j = 0; j < int'(nj); j++) begin
                do b = 8'($urandom); while (b == SYNC);
                drive_byte(b);
            end
            fr[0] = SYNC;
            fr[1] = 8'($urandom);
            fr[2] = 8'($urandom);
            fr[3] = 8'($urandom);
            fr[4] = fr[1] ^ fr[2] ^ fr[3];
            if ($urandom_range(0, 3) == 0) fr[4] = fr[4] ^ 8'($urandom_range(1, 255));
            stall_pos = $urandom_range(0, 7);
            case ($urandom_range(0, 3))
                0:       gap = 5;
                1:       gap = TIMEOUT;
                2:       gap = TIMEOUT + 1;
                default: gap = TIMEOUT + 30;
            endcase
            for (int unsigned k = 0; k < 5; k++) begin
                if (k == stall_pos && k > 0) idle(gap);
                drive_byte(fr[k]);
            end
            if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
        end
        idle(TIMEOUT + 10);
        finish_scenario("random");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
